// File: rtl/si5340_init_sequencer.sv
// Bring-up and supervision FSM for the Si5340 config path: power-up delay, loader
// load/write handshake, PLL lock qualification, bounded retry and a single ready/fail status.
module si5340_init_sequencer #(
    parameter bit AUTO_START       = 1'b1,
    parameter int PWRUP_CYC        = 1000,
    parameter int WRITE_TO_CYC     = 2000000,
    parameter int LOCK_STABLE_CYC  = 1000,
    parameter int LOCK_TO_CYC      = 5000000,
    parameter int LOL_DEBOUNCE_CYC = 16,
    parameter int RETRY_DELAY_CYC  = 1000,
    parameter int MAX_RETRY        = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       loader_busy_i,
    input  logic       loader_done_i,
    input  logic       loader_err_i,
    input  logic       lol_i,
    output logic       load_o,
    output logic       write_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [3:0] retry_cnt_o,
    output logic [3:0] state_o
);
    localparam int M0 = (PWRUP_CYC > WRITE_TO_CYC) ? PWRUP_CYC : WRITE_TO_CYC;
    localparam int M1 = (M0 > LOCK_STABLE_CYC) ? M0 : LOCK_STABLE_CYC;
    localparam int M2 = (M1 > LOCK_TO_CYC) ? M1 : LOCK_TO_CYC;
    localparam int M3 = (M2 > LOL_DEBOUNCE_CYC) ? M2 : LOL_DEBOUNCE_CYC;
    localparam int MAX_CYC = (M3 > RETRY_DELAY_CYC) ? M3 : RETRY_DELAY_CYC;
    localparam int CW = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] PWRUP_LD  = CW'(PWRUP_CYC - 1);
    localparam logic [CW-1:0] BUSY_LD   = CW'(WRITE_TO_CYC - 1);
    localparam logic [CW-1:0] LOCKTO_LD = CW'(LOCK_TO_CYC - 1);
    localparam logic [CW-1:0] RETRY_LD  = CW'(RETRY_DELAY_CYC - 1);
    localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(LOL_DEBOUNCE_CYC - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        PWRUP     = 4'd1,
        LOAD      = 4'd2,
        WRITE     = 4'd3,
        BUSY      = 4'd4,
        LOCK_WAIT = 4'd5,
        LOCKED    = 4'd6,
        FAIL      = 4'd7,
        RETRY     = 4'd8
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] stab_q, stab_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [3:0]    retry_q, retry_d;
    logic          err;

    // Loader busy is only status; the done/err pulses carry the handshake.
    logic unused_busy;
    assign unused_busy = loader_busy_i;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        stab_d  = '0;
        deb_d   = '0;
        err     = 1'b0;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;

        case (state_q)
            IDLE: begin
                if (AUTO_START || start_i) begin
                    state_d = PWRUP;
                    retry_d = '0;
                end
            end
            PWRUP:  if (cnt_q == '0) state_d = LOAD;
            LOAD:   state_d = WRITE;
            WRITE:  state_d = BUSY;
            BUSY: begin
                // err dominates a coincident done
                if (loader_err_i)       err = 1'b1;
                else if (loader_done_i) state_d = LOCK_WAIT;
                else if (cnt_q == '0)   err = 1'b1;
            end
            LOCK_WAIT: begin
                if (!lol_i && stab_q == STAB_LAST) state_d = LOCKED;
                else if (cnt_q == '0)             err = 1'b1;
                else                              stab_d = lol_i ? '0 : stab_q + 1'b1;
            end
            LOCKED: begin
                if (start_i) begin
                    state_d = PWRUP;
                    retry_d = '0;
                end else if (lol_i) begin
                    if (deb_q == DEB_LAST) err = 1'b1;
                    else                   deb_d = deb_q + 1'b1;
                end
            end
            FAIL: begin
                if (start_i) begin
                    state_d = PWRUP;
                    retry_d = '0;
                end
            end
            RETRY:  if (cnt_q == '0) state_d = LOAD;
            default: state_d = IDLE;
        endcase

        if (err) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = RETRY;
            end else begin
                state_d = FAIL;
            end
        end

        // Shared timer reloads on entry so each timed state sees a full window.
        if (state_d != state_q) begin
            case (state_d)
                PWRUP:     cnt_d = PWRUP_LD;
                BUSY:      cnt_d = BUSY_LD;
                LOCK_WAIT: cnt_d = LOCKTO_LD;
                RETRY:     cnt_d = RETRY_LD;
                default:   cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stab_q  <= '0;
            deb_q   <= '0;
            retry_q <= '0;
            load_o  <= 1'b0;
            write_o <= 1'b0;
            ready_o <= 1'b0;
            fail_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stab_q  <= stab_d;
            deb_q   <= deb_d;
            retry_q <= retry_d;
            load_o  <= (state_d == LOAD);
            write_o <= (state_d == WRITE);
            ready_o <= (state_d == LOCKED);
            fail_o  <= (state_d == FAIL);
        end
    end

    assign state_o     = state_q;
    assign retry_cnt_o = retry_q;
endmodule

// File: doc/si5340_init_sequencer.md
# si5340_init_sequencer

Bring-up and supervision controller for the Si5340 configuration path. It drives the config loader's `load`/`write` commands after a power-up delay and waits for loader completion. It then qualifies PLL lock from the device LOL pin and retries the full configuration on error, timeout or lock loss, up to a bounded retry count. It sits between the board reset/control logic and `si5340_config_loader`, and gives the rest of the design a single `ready_o`/`fail_o` status.

## Interface
- `AUTO_START`, 1: 1 = start the sequence automatically after reset; 0 = wait for `start_i`.
- `PWRUP_CYC`, 1000: cycles spent in PWRUP before the first load.
- `WRITE_TO_CYC`, 2000000: maximum cycles in BUSY before a timeout is declared.
- `LOCK_STABLE_CYC`, 1000: consecutive cycles with `lol_i`=0 required to declare lock.
- `LOCK_TO_CYC`, 5000000: maximum cycles in LOCK_WAIT.
- `LOL_DEBOUNCE_CYC`, 16: consecutive cycles with `lol_i`=1 in LOCKED that count as lock loss.
- `RETRY_DELAY_CYC`, 1000: cycles spent in RETRY before reloading.
- `MAX_RETRY`, 3: number of retries before FAIL; range 1..15.
- `clk_i`  in  1  system clock; the only clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  one-cycle request to (re)start the sequence.
- `loader_busy_i`  in  1  loader is executing; informational only.
- `loader_done_i`  in  1  one-cycle pulse: loader write completed OK.
- `loader_err_i`  in  1  one-cycle pulse: loader error (I2C NACK/arbitration).
- `lol_i`  in  1  Si5340 loss-of-lock, active-high; already synchronised to `clk_i`.
- `load_o`  out  1  one-cycle load command to the loader.
- `write_o`  out  1  one-cycle write command to the loader.
- `ready_o`  out  1  high while in LOCKED.
- `fail_o`  out  1  high while in FAIL.
- `retry_cnt_o`  out  4  retries consumed since the last start.
- `state_o`  out  4  FSM state encoding, for debug.

## Operation
- State encodings: IDLE=0, PWRUP=1, LOAD=2, WRITE=3, BUSY=4, LOCK_WAIT=5, LOCKED=6, FAIL=7, RETRY=8.
- IDLE → PWRUP when `AUTO_START`=1 (first cycle after reset) or when `start_i`=1.
- PWRUP → LOAD after exactly `PWRUP_CYC` cycles.
- LOAD lasts 1 cycle; `load_o`=1 during it. LOAD → WRITE.
- WRITE lasts 1 cycle; `write_o`=1 during it. WRITE → BUSY.
- BUSY:
  - `loader_done_i` → LOCK_WAIT.
  - `loader_err_i`, or `WRITE_TO_CYC` cycles elapsed → error.
  - If `loader_done_i` and `loader_err_i` arrive in the same cycle, err wins.
- LOCK_WAIT:
  - A stability counter increments while `lol_i`=0 and clears to 0 on `lol_i`=1.
  - Reaching `LOCK_STABLE_CYC` → LOCKED.
  - `LOCK_TO_CYC` cycles in the state without reaching it → error.
- LOCKED: `lol_i`=1 for `LOL_DEBOUNCE_CYC` consecutive cycles → error. Shorter glitches are ignored and reset the debounce counter.
- Error handling:
  - If `retry_cnt` < `MAX_RETRY`: `retry_cnt` += 1, go to RETRY.
  - Otherwise go to FAIL; `retry_cnt` stays at `MAX_RETRY` and never wraps.
- RETRY → LOAD after exactly `RETRY_DELAY_CYC` cycles. PWRUP is not repeated.
- `start_i` is honoured only in IDLE, LOCKED and FAIL. In each case it clears `retry_cnt` and enters PWRUP. It is ignored in all other states.
- One shared down-counter serves PWRUP, BUSY, LOCK_WAIT and RETRY timing. It is reloaded on every state entry.
- Width rule: counter width = clog2 of the largest cycle parameter, plus 1 bit.

## Timing
- All outputs are registered. Reset values: `load_o`=0, `write_o`=0, `ready_o`=0, `fail_o`=0, `retry_cnt_o`=0, `state_o`=0 (IDLE). All internal counters are 0.
- `rst_i` is sampled on the clock edge. When asserted in any state, including BUSY mid-transaction, the next cycle is IDLE with all outputs at reset values. The loader is not notified.
- With `AUTO_START`=1 and `rst_i` released at cycle 0:
  - IDLE occupies cycle 1.
  - PWRUP occupies cycles 2..`PWRUP_CYC`+1.
  - `load_o` is high in cycle `PWRUP_CYC`+2.
  - `write_o` is high in cycle `PWRUP_CYC`+3.
- Done → LOCK_WAIT transition: a `loader_done_i` sampled in cycle t puts `state_o`=5 in cycle t+1.
- `ready_o` rises in the same cycle `state_o` becomes 6, and falls in the cycle the FSM leaves LOCKED.
- `load_o` and `write_o` are never high simultaneously and are never high for more than one cycle.

## Test plan
Bench parameters for all scenarios: `PWRUP_CYC`=10, `WRITE_TO_CYC`=50, `LOCK_STABLE_CYC`=8, `LOCK_TO_CYC`=40, `LOL_DEBOUNCE_CYC`=4, `RETRY_DELAY_CYC`=5, `MAX_RETRY`=3.

1. Nominal bring-up:
   - Stimulus: reset release; `loader_done_i` pulsed 20 cycles after `write_o`; `lol_i`=0 throughout.
   - Required: `load_o` at cycle 12, `write_o` at cycle 13; `ready_o`=1 exactly 8 cycles after LOCK_WAIT entry; `retry_cnt_o`=0.
2. Loader error, then success:
   - Stimulus: `loader_err_i` on the first pass, `loader_done_i` on the second.
   - Required: RETRY for 5 cycles, then a single `load_o` with no PWRUP; `retry_cnt_o`=1; ends in LOCKED.
3. Exhausted retries:
   - Stimulus: `loader_done_i` never pulses.
   - Required: four BUSY timeouts of 50 cycles each; `fail_o`=1, `retry_cnt_o`=3, `state_o`=7. A subsequent `start_i` clears `retry_cnt_o` to 0 and enters PWRUP.
4. Lock qualification and loss:
   - Stimulus: `lol_i` 3-cycle glitch inside the 8-cycle window.
   - Required: the stability counter restarts.
   - Stimulus: in LOCKED, a 3-cycle `lol_i` pulse.
   - Required: no change.
   - Stimulus: in LOCKED, a 4-cycle `lol_i` pulse.
   - Required: `ready_o` falls, `retry_cnt_o`=1, state RETRY.
5. Simultaneous `loader_done_i` and `loader_err_i` in BUSY → treated as error (RETRY).
6. `rst_i` asserted in BUSY, and separately `start_i` asserted in BUSY:
   - `rst_i` → IDLE next cycle with all outputs at reset values.
   - `start_i` → no effect.
